// File: rtl/galvani_trig_pkg.sv
// Shared types and constants for the trigger event encoder: event record, frame layout
// and serializer states.
package galvani_trig_pkg;

  localparam int unsigned CH_W    = 7;
  localparam int unsigned TS_W    = 16;
  localparam int unsigned FRAME_W = 26;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [TS_W-1:0] ts;
  } trig_evt_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } ser_state_e;

  // Frame is sent MSB first: start, channel, timestamp, even parity, stop.
  function automatic logic [FRAME_W-1:0] build_frame(input trig_evt_t evt);
    return {START_BIT, evt.ch, evt.ts, ^{evt.ch, evt.ts}, STOP_BIT};
  endfunction

endpackage

// File: rtl/trig_evt_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured trigger events.
module trig_evt_fifo #(
  parameter int unsigned Width = 23,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW + 1)'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    level_d = level_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/trig_event_encoder.sv
// Captures rising edges on the stim trigger bus, timestamps and queues them, and serialises
// each event as a 26-bit frame on a single pin for the acquisition card.
module trig_event_encoder
  import galvani_trig_pkg::*;
#(
  parameter int unsigned NTrig     = 128,
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned BitDiv    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NTrig-1:0]             trig_i,
  input  logic                         sync_i,
  input  logic                         enable_i,
  output logic                         ser_o,
  output logic                         busy_o,
  output logic                         overflow_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o,
  output logic [15:0]                  event_count_o
);

  localparam int unsigned DivW = (BitDiv > 1) ? $clog2(BitDiv) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(BitDiv - 1);

  // Edge capture and pending set
  logic             prime_q;
  logic [NTrig-1:0] trig_q, trig_qq;
  logic [NTrig-1:0] edge_vec, pending_q, pending_d, pop_mask;
  logic [CH_W-1:0]  push_ch;
  logic             push;
  logic             overflow_q;
  logic [15:0]      event_count_q;
  logic [TS_W-1:0]  ts_q, ts_d;

  // FIFO and serializer
  trig_evt_t        push_evt, head_evt;
  logic             fifo_full, fifo_empty, fifo_pop;
  ser_state_e       state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [4:0]       bit_q, bit_d;
  logic [DivW-1:0]  div_q, div_d;

  assign edge_vec  = trig_q & ~trig_qq & {NTrig{enable_i}};
  assign push      = (|pending_q) & ~fifo_full;
  assign pending_d = (pending_q & ~pop_mask) | edge_vec;
  assign ts_d      = sync_i ? '0 : ts_q + 1'b1;

  // Lowest-index pending channel wins.
  always_comb begin
    push_ch = '0;
    for (int i = int'(NTrig) - 1; i >= 0; i--) begin
      if (pending_q[i]) push_ch = CH_W'(i);
    end
  end

  always_comb begin
    pop_mask = '0;
    if (push) pop_mask[push_ch] = 1'b1;
  end

  // The stored timestamp is the value ts takes at the push edge.
  assign push_evt = '{ch: push_ch, ts: ts_d};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prime_q       <= 1'b1;
      trig_q        <= '0;
      trig_qq       <= '0;
      pending_q     <= '0;
      overflow_q    <= 1'b0;
      event_count_q <= '0;
      ts_q          <= '0;
    end else begin
      prime_q <= 1'b0;
      trig_q  <= trig_i;
      // Priming makes lines already high at reset exit look steady.
      trig_qq <= prime_q ? trig_i : trig_q;
      pending_q     <= pending_d;
      overflow_q    <= overflow_q | (|(edge_vec & pending_q & ~pop_mask));
      event_count_q <= event_count_q + 16'(push);
      ts_q          <= ts_d;
    end
  end

  trig_evt_fifo #(
    .Width ($bits(trig_evt_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_evt),
    .pop_i   (fifo_pop),
    .data_o  (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    div_d    = div_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = build_frame(head_evt);
          bit_d    = 5'(FRAME_W - 1);
          div_d    = DivMax;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (div_q == '0) begin
          div_d = DivMax;
          if (bit_q == '0) begin
            state_d = StGap;
          end else begin
            bit_d = bit_q - 1'b1;
            sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StGap: begin
        if (div_q == '0) begin
          // Chain straight into the next frame so spacing stays at 27 bit periods.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = build_frame(head_evt);
            bit_d    = 5'(FRAME_W - 1);
            div_d    = DivMax;
            state_d  = StShift;
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  assign ser_o         = (state_q == StShift) & sh_q[FRAME_W-1];
  assign busy_o        = (state_q != StIdle);
  assign overflow_o    = overflow_q;
  assign event_count_o = event_count_q;

endmodule

// File: tb/tb_trig_event_encoder.sv
// Scoreboard bench for trig_event_encoder: directed stimulus queues expected frames, a monitor
// decodes ser_o and compares each frame in order.
module tb_trig_event_encoder;

  localparam int unsigned NTrig     = 128;
  localparam int unsigned FifoDepth = 16;
  localparam int unsigned BitDiv    = 4;
  localparam int unsigned FrameW    = 26;
  localparam int unsigned LvlW      = $clog2(FifoDepth) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NTrig-1:0]  trig_i = '0;
  logic              sync_i = 1'b0;
  logic              enable_i = 1'b1;
  logic              ser_o, busy_o, overflow_o;
  logic [LvlW-1:0]   fifo_level_o;
  logic [15:0]       event_count_o;

  trig_event_encoder #(
    .NTrig     (NTrig),
    .FifoDepth (FifoDepth),
    .BitDiv    (BitDiv)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .trig_i        (trig_i),
    .sync_i        (sync_i),
    .enable_i      (enable_i),
    .ser_o         (ser_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .fifo_level_o  (fifo_level_o),
    .event_count_o (event_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Edges since reset release; read at negedges.
  int unsigned cyc;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int frames_seen = 0;
  int n_events = 0;
  int unsigned sync_edge = 0;
  logic [FrameW-1:0] exp_q[$];
  int unsigned start_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [FrameW-1:0] mk_frame(input int unsigned ch, input logic [15:0] ts);
    logic [6:0] c7;
    c7 = 7'(ch);
    return {1'b1, c7, ts, ^{c7, ts}, 1'b0};
  endfunction

  function automatic logic [15:0] ts_at(input int unsigned push_edge);
    return 16'(push_edge - sync_edge);
  endfunction

  task automatic expect_evt(input int unsigned ch, input logic [15:0] ts);
    exp_q.push_back(mk_frame(ch, ts));
    n_events++;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk_i);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int b;
    b = 0;
    while (frames_seen < target && b < budget) begin
      @(negedge clk_i);
      b++;
    end
    check(name, 32'(frames_seen >= target), 32'd1);
  endtask

  task automatic do_reset(input logic [NTrig-1:0] held);
    rst_i = 1'b1;
    trig_i = held;
    repeat (4) @(negedge clk_i);
    exp_q.delete();
    n_events  = 0;
    sync_edge = 0;
    rst_i = 1'b0;
  endtask

  initial begin : monitor
    logic [FrameW-1:0] fr;
    logic busy_ok;
    bit aborted;
    forever begin
      @(negedge clk_i);
      if (!rst_i && ser_o) begin
        start_log.push_back(cyc);
        fr = '0;
        fr[FrameW-1] = 1'b1;
        busy_ok = busy_o;
        aborted = 1'b0;
        for (int i = FrameW - 2; i >= 0; i--) begin
          repeat (BitDiv) @(negedge clk_i);
          if (rst_i) begin
            aborted = 1'b1;
            break;
          end
          fr[i] = ser_o;
          busy_ok = busy_ok & busy_o;
        end
        if (!aborted) begin
          repeat (BitDiv) @(negedge clk_i);
          for (int g = 0; g < int'(BitDiv); g++) begin
            if (g != 0) @(negedge clk_i);
            if (rst_i) aborted = 1'b1;
            busy_ok = busy_ok & busy_o & ~ser_o;
          end
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: got 0x%0h, want no frame", fr);
          end else begin
            check("frame", 32'(fr), 32'(exp_q.pop_front()));
            check("frame_busy_gap", 32'(busy_ok), 32'd1);
          end
          frames_seen++;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin : stim
    int unsigned c, s, d;
    int f0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ser", 32'(ser_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_overflow", 32'(overflow_o), 0);
    check("rst_level", 32'(fifo_level_o), 0);
    check("rst_count", 32'(event_count_o), 0);
    rst_i = 1'b0;

    // Single edge on ch 5: rise sampled at edge 10, push at 12, start bit at 13
    wait_cyc(9);
    trig_i[5] = 1'b1;
    expect_evt(5, 16'd12);
    repeat (2) @(negedge clk_i);
    trig_i[5] = 1'b0;
    wait_frames(1, 300, "single_done");
    check("single_start_cyc", start_log[start_log.size()-1], 32'd13);
    @(negedge clk_i);
    check("single_busy_fall", 32'(busy_o), 0);
    check("single_count", 32'(event_count_o), 32'(n_events));

    // Simultaneous edges: ch 3 then ch 100, back to back
    c = cyc;
    trig_i[3] = 1'b1;
    trig_i[100] = 1'b1;
    expect_evt(3, ts_at(c + 3));
    expect_evt(100, ts_at(c + 4));
    @(negedge clk_i);
    trig_i = '0;
    wait_frames(3, 400, "simul_done");
    check("simul_spacing", start_log[start_log.size()-1] - start_log[start_log.size()-2],
          32'd108);
    check("simul_overflow", 32'(overflow_o), 0);

    // Sync then edge on ch 0 pushed 10 edges after the sync edge
    c = cyc;
    sync_i = 1'b1;
    sync_edge = c + 1;
    @(negedge clk_i);
    sync_i = 1'b0;
    wait_cyc(sync_edge + 7);
    trig_i[0] = 1'b1;
    expect_evt(0, 16'd10);
    @(negedge clk_i);
    trig_i = '0;
    wait_frames(4, 300, "sync_done");

    // Timestamp wrap: pushes land on ts 0xFFFF and 0x0000
    c = cyc;
    sync_i = 1'b1;
    s = c + 1;
    sync_edge = s;
    @(negedge clk_i);
    sync_i = 1'b0;
    d = s + 65532;
    wait_cyc(d);
    trig_i[1] = 1'b1;
    trig_i[2] = 1'b1;
    expect_evt(1, 16'hFFFF);
    expect_evt(2, 16'h0000);
    @(negedge clk_i);
    trig_i = '0;
    wait_frames(6, 400, "wrap_done");

    // Stall: 20 channels one per cycle, FIFO fills, 3 wait in pending
    c = cyc;
    for (int j = 0; j < 20; j++) begin
      if (j <= 16)      expect_evt(20 + j, ts_at(c + j + 3));
      else if (j == 17) expect_evt(20 + j, ts_at(c + 113));
      else if (j == 18) expect_evt(20 + j, ts_at(c + 221));
      else              expect_evt(20 + j, ts_at(c + 329));
    end
    for (int j = 0; j < 20; j++) begin
      trig_i = '0;
      trig_i[20 + j] = 1'b1;
      @(negedge clk_i);
    end
    trig_i = '0;
    check("stall_level_full", 32'(fifo_level_o), 32'd16);
    // Re-pulse ch 39 while it is still pending
    wait_cyc(c + 99);
    check("dup_overflow_before", 32'(overflow_o), 0);
    trig_i[39] = 1'b1;
    @(negedge clk_i);
    trig_i = '0;
    wait_cyc(c + 103);
    check("dup_overflow_set", 32'(overflow_o), 32'd1);
    wait_frames(26, 3000, "stall_done");
    repeat (150) @(negedge clk_i);
    check("stall_frames_total", 32'(frames_seen), 32'd26);
    check("stall_count", 32'(event_count_o), 32'(n_events));
    check("overflow_sticky", 32'(overflow_o), 32'd1);

    // Held level produces one event
    c = cyc;
    trig_i[7] = 1'b1;
    expect_evt(7, ts_at(c + 3));
    repeat (500) @(negedge clk_i);
    trig_i = '0;
    wait_frames(27, 300, "level_done");
    check("level_one_frame", 32'(frames_seen), 32'd27);

    // Disabled capture
    enable_i = 1'b0;
    @(negedge clk_i);
    trig_i[9] = 1'b1;
    @(negedge clk_i);
    trig_i = '0;
    repeat (4) @(negedge clk_i);
    enable_i = 1'b1;
    repeat (200) @(negedge clk_i);
    check("disabled_no_frame", 32'(frames_seen), 32'd27);
    check("disabled_count", 32'(event_count_o), 32'(n_events));

    // Line high through reset release
    do_reset(128'd4);
    check("reset_clears_overflow", 32'(overflow_o), 0);
    repeat (50) @(negedge clk_i);
    check("held_count", 32'(event_count_o), 0);
    trig_i = '0;
    repeat (200) @(negedge clk_i);
    check("held_no_frame", 32'(frames_seen), 32'd27);

    // Reset in the middle of a frame with two events still queued
    c = cyc;
    trig_i[11] = 1'b1;
    trig_i[12] = 1'b1;
    trig_i[13] = 1'b1;
    @(negedge clk_i);
    trig_i = '0;
    wait_cyc(c + 45);
    check("midrst_busy_before", 32'(busy_o), 32'd1);
    check("midrst_level_before", 32'(fifo_level_o), 32'd2);
    #1 rst_i = 1'b1;
    #1;
    check("midrst_ser", 32'(ser_o), 0);
    check("midrst_busy", 32'(busy_o), 0);
    f0 = frames_seen;
    repeat (6) @(negedge clk_i);
    exp_q.delete();
    n_events = 0;
    sync_edge = 0;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("midrst_level", 32'(fifo_level_o), 0);
    check("midrst_count", 32'(event_count_o), 0);
    repeat (300) @(negedge clk_i);
    check("midrst_no_frame", 32'(frames_seen), 32'(f0));

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
